decoinv_enc: RTL and testbench

//  Level-to-code encoder; inverse of the level decoder (code 0..4 -> level 5..1, other codes -> 0).

---
 rtl/decoinv_enc_pkg.sv | 26 ++
 rtl/decoinv_enc_if.sv | 20 ++
 rtl/decoinv_enc_edge_rise.sv | 23 ++
 rtl/decoinv_enc.sv | 153 +++++++++++++++
 tb/tb_decoinv_enc.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/decoinv_enc_pkg.sv
// Shared definitions for the level-to-code encoder and the decoder-side checkers.
// Holds the default level range, the "off" code, the state encoding and the code map.
package decoinv_pkg;

  localparam int          LVL_MAX_DEF  = 5;
  localparam logic [3:0]  CODE_OFF_DEF = 4'hF;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  // Level 0 maps to the off code; higher levels count down from lvl_max.
  function automatic logic [3:0] lvl_to_code(input logic [3:0] level,
                                             input logic [3:0] lvl_max,
                                             input logic [3:0] code_off);
    logic [3:0] code;
    if (level == 4'd0) begin
      code = code_off;
    end else begin
      code = lvl_max - level;
    end
    return code;
  endfunction

endpackage

// File: rtl/decoinv_enc_if.sv
// Code handshake between the encoder (master) and the level decoder (slave).
interface decoinv_enc_if;

  logic [3:0] code_o;
  logic       code_valid_o;
  logic       code_ready_i;

  modport master (
    output code_o,
    output code_valid_o,
    input  code_ready_i
  );

  modport slave (
    input  code_o,
    input  code_valid_o,
    output code_ready_i
  );

endinterface

// File: rtl/decoinv_enc_edge_rise.sv
// Rising-edge detector for a synchronised level input.
// History resets to 1 so an input already high when reset releases is not an edge.
module edge_rise (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic rise
);

  logic q_r;

  // History register of the previous input value.
  always_ff @(posedge clk) begin
    if (reset) begin
      q_r <= 1'b1;
    end else begin
      q_r <= d;
    end
  end

  assign rise = d & ~q_r;

endmodule

// File: rtl/decoinv_enc.sv
// Level-to-code encoder: keeps a user level stepped by buttons or loaded directly,
// and sends the latest level's code to the decoder over a valid/ready handshake.
module decoinv_enc
  import decoinv_pkg::*;
#(
  parameter int         LVL_MAX  = LVL_MAX_DEF,
  parameter logic [3:0] CODE_OFF = CODE_OFF_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              inc_i,
  input  logic              dec_i,
  input  logic              load_i,
  input  logic [3:0]        value_i,
  output logic [3:0]        level_o,
  output logic              err_o,
  decoinv_enc_if.master     bus
);

  localparam logic [3:0] LMAX    = 4'(LVL_MAX);
  localparam logic [0:0] ST_IDLE = IDLE;
  localparam logic [0:0] ST_SEND = SEND;

  logic       inc_edge_s;
  logic       dec_edge_s;
  logic [3:0] level_r;
  logic [3:0] level_nxt_s;
  logic       chg_s;
  logic       err_r;
  logic       err_nxt_s;
  logic [0:0] state_r;
  logic [0:0] state_nxt_s;
  logic [3:0] code_r;
  logic [3:0] code_nxt_s;
  logic       valid_r;
  logic       valid_nxt_s;
  logic       pending_r;
  logic       pending_nxt_s;

  edge_rise u_inc_edge (
    .clk   (clk),
    .reset (reset),
    .d     (inc_i),
    .rise  (inc_edge_s)
  );

  edge_rise u_dec_edge (
    .clk   (clk),
    .reset (reset),
    .d     (dec_i),
    .rise  (dec_edge_s)
  );

  // Next level and change flag; an out-of-range load blocks the buttons too.
  always_comb begin
    level_nxt_s = level_r;
    chg_s       = 1'b0;
    err_nxt_s   = 1'b0;
    if (load_i) begin
      if (value_i <= LMAX) begin
        level_nxt_s = value_i;
        chg_s       = 1'b1;
      end else begin
        err_nxt_s   = 1'b1;
      end
    end else if (inc_edge_s && dec_edge_s) begin
      level_nxt_s = level_r;
    end else if (inc_edge_s) begin
      if (level_r < LMAX) begin
        level_nxt_s = level_r + 4'd1;
        chg_s       = 1'b1;
      end else begin
        level_nxt_s = level_r;
      end
    end else if (dec_edge_s) begin
      if (level_r != 4'd0) begin
        level_nxt_s = level_r - 4'd1;
        chg_s       = 1'b1;
      end else begin
        level_nxt_s = level_r;
      end
    end else begin
      level_nxt_s = level_r;
    end
  end

  // Handshake FSM: code is frozen under backpressure, only the newest level is resent.
  always_comb begin
    state_nxt_s   = state_r;
    code_nxt_s    = code_r;
    valid_nxt_s   = valid_r;
    pending_nxt_s = pending_r;
    case (state_r)
      ST_IDLE: begin
        if (chg_s) begin
          code_nxt_s    = lvl_to_code(level_nxt_s, LMAX, CODE_OFF);
          valid_nxt_s   = 1'b1;
          pending_nxt_s = 1'b0;
          state_nxt_s   = ST_SEND;
        end else begin
          valid_nxt_s   = 1'b0;
        end
      end
      ST_SEND: begin
        if (bus.code_ready_i) begin
          pending_nxt_s = 1'b0;
          if (pending_r || chg_s) begin
            code_nxt_s  = lvl_to_code(level_nxt_s, LMAX, CODE_OFF);
            valid_nxt_s = 1'b1;
            state_nxt_s = ST_SEND;
          end else begin
            valid_nxt_s = 1'b0;
            state_nxt_s = ST_IDLE;
          end
        end else if (chg_s) begin
          pending_nxt_s = 1'b1;
        end else begin
          pending_nxt_s = pending_r;
        end
      end
      default: begin
        state_nxt_s   = ST_IDLE;
        valid_nxt_s   = 1'b0;
        pending_nxt_s = 1'b0;
      end
    endcase
  end

  // State, level, code and error registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      level_r   <= 4'd0;
      err_r     <= 1'b0;
      state_r   <= ST_IDLE;
      code_r    <= CODE_OFF;
      valid_r   <= 1'b0;
      pending_r <= 1'b0;
    end else begin
      level_r   <= level_nxt_s;
      err_r     <= err_nxt_s;
      state_r   <= state_nxt_s;
      code_r    <= code_nxt_s;
      valid_r   <= valid_nxt_s;
      pending_r <= pending_nxt_s;
    end
  end

  assign level_o          = level_r;
  assign err_o            = err_r;
  assign bus.code_o       = code_r;
  assign bus.code_valid_o = valid_r;

endmodule

// File: tb/tb_decoinv_enc.sv
// Directed bench for decoinv_enc: a vector table for single-cycle behaviour
// plus hand-written sequences for reset, backpressure and reset-during-send.
module tb_decoinv_enc;

  typedef struct {
    logic       inc;
    logic       dec;
    logic       load;
    logic [3:0] value;
    logic       ready;
    logic [3:0] lvl;
    logic [3:0] code;
    logic       vld;
    logic       err;
  } vec_t;

  logic       clk;
  logic       reset;
  logic       inc_i;
  logic       dec_i;
  logic       load_i;
  logic [3:0] value_i;
  logic [3:0] level_o;
  logic       err_o;
  int         total;
  int         bad;
  vec_t       vq[$];

  decoinv_enc_if bus ();

  decoinv_enc dut (
    .clk     (clk),
    .reset   (reset),
    .inc_i   (inc_i),
    .dec_i   (dec_i),
    .load_i  (load_i),
    .value_i (value_i),
    .level_o (level_o),
    .err_o   (err_o),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference decoder: code 0..4 -> level 5..1, anything else -> 0.
  function automatic logic [3:0] decode(input logic [3:0] code);
    logic [3:0] lvl;
    case (code)
      4'd0:    lvl = 4'd5;
      4'd1:    lvl = 4'd4;
      4'd2:    lvl = 4'd3;
      4'd3:    lvl = 4'd2;
      4'd4:    lvl = 4'd1;
      default: lvl = 4'd0;
    endcase
    return lvl;
  endfunction

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic inc, input logic dec, input logic load, input logic [3:0] value,
                     input logic ready, input logic [3:0] lvl, input logic [3:0] code,
                     input logic vld, input logic err);
    vec_t v;
    v.inc = inc; v.dec = dec; v.load = load; v.value = value; v.ready = ready;
    v.lvl = lvl; v.code = code; v.vld = vld; v.err = err;
    vq.push_back(v);
  endtask

  task automatic check_state(input string tag, input logic [3:0] lvl, input logic [3:0] code,
                             input logic vld, input logic err);
    check({tag, " level"}, level_o, lvl);
    check({tag, " valid"}, {3'd0, bus.code_valid_o}, {3'd0, vld});
    check({tag, " err"}, {3'd0, err_o}, {3'd0, err});
    if (vld) begin
      check({tag, " code"}, bus.code_o, code);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    inc_i = 1'b1;
    dec_i = 1'b0;
    load_i = 1'b0;
    value_i = 4'd0;
    bus.code_ready_i = 1'b1;

    // Reset with inc held: no step on release, one step on re-press.
    cyc();
    cyc();
    check_state("rst", 4'd0, 4'hF, 1'b0, 1'b0);
    check("rst code", bus.code_o, 4'hF);
    reset = 1'b0;
    cyc();
    check_state("held", 4'd0, 4'hF, 1'b0, 1'b0);
    inc_i = 1'b0;
    cyc();
    inc_i = 1'b1;
    cyc();
    check_state("repress", 4'd1, 4'd4, 1'b1, 1'b0);
    inc_i = 1'b0;
    cyc();
    check_state("repress done", 4'd1, 4'd4, 1'b0, 1'b0);

    // Vector table, ready held high; starts at level 1, IDLE.
    add(1'b0,1'b0,1'b1,4'd0,1'b1, 4'd0,4'hF,1'b1,1'b0);
    add(1'b0,1'b0,1'b1,4'd0,1'b1, 4'd0,4'hF,1'b1,1'b0); // equal value still sends
    add(1'b0,1'b0,1'b0,4'd0,1'b1, 4'd0,4'hF,1'b0,1'b0);
    add(1'b1,1'b0,1'b0,4'd0,1'b1, 4'd1,4'd4,1'b1,1'b0);
    add(1'b1,1'b0,1'b0,4'd0,1'b1, 4'd1,4'd4,1'b0,1'b0); // held, no second step
    add(1'b0,1'b0,1'b0,4'd0,1'b1, 4'd1,4'd4,1'b0,1'b0);
    add(1'b1,1'b0,1'b0,4'd0,1'b1, 4'd2,4'd3,1'b1,1'b0);
    add(1'b0,1'b0,1'b0,4'd0,1'b1, 4'd2,4'd3,1'b0,1'b0);
    add(1'b1,1'b0,1'b0,4'd0,1'b1, 4'd3,4'd2,1'b1,1'b0);
    add(1'b0,1'b0,1'b0,4'd0,1'b1, 4'd3,4'd2,1'b0,1'b0);
    add(1'b1,1'b0,1'b0,4'd0,1'b1, 4'd4,4'd1,1'b1,1'b0);
    add(1'b0,1'b0,1'b0,4'd0,1'b1, 4'd4,4'd1,1'b0,1'b0);
    add(1'b1,1'b0,1'b0,4'd0,1'b1, 4'd5,4'd0,1'b1,1'b0);
    add(1'b0,1'b0,1'b0,4'd0,1'b1, 4'd5,4'd0,1'b0,1'b0);
    add(1'b1,1'b0,1'b0,4'd0,1'b1, 4'd5,4'd0,1'b0,1'b0); // saturated at top
    add(1'b0,1'b0,1'b0,4'd0,1'b1, 4'd5,4'd0,1'b0,1'b0);
    add(1'b1,1'b0,1'b1,4'd9,1'b1, 4'd5,4'd0,1'b0,1'b1); // bad load also masks inc
    add(1'b0,1'b0,1'b0,4'd0,1'b1, 4'd5,4'd0,1'b0,1'b0);
    add(1'b0,1'b0,1'b1,4'd2,1'b1, 4'd2,4'd3,1'b1,1'b0);
    add(1'b0,1'b0,1'b0,4'd0,1'b1, 4'd2,4'd3,1'b0,1'b0);
    add(1'b1,1'b1,1'b0,4'd0,1'b1, 4'd2,4'd3,1'b0,1'b0); // opposing edges cancel
    add(1'b0,1'b0,1'b0,4'd0,1'b1, 4'd2,4'd3,1'b0,1'b0);
    add(1'b0,1'b0,1'b1,4'd1,1'b1, 4'd1,4'd4,1'b1,1'b0);
    add(1'b0,1'b0,1'b0,4'd0,1'b1, 4'd1,4'd4,1'b0,1'b0);
    add(1'b0,1'b1,1'b0,4'd0,1'b1, 4'd0,4'hF,1'b1,1'b0);
    add(1'b0,1'b0,1'b0,4'd0,1'b1, 4'd0,4'hF,1'b0,1'b0);
    add(1'b0,1'b1,1'b0,4'd0,1'b1, 4'd0,4'hF,1'b0,1'b0); // saturated at bottom
    add(1'b0,1'b0,1'b0,4'd0,1'b1, 4'd0,4'hF,1'b0,1'b0);
    add(1'b0,1'b0,1'b1,4'd5,1'b1, 4'd5,4'd0,1'b1,1'b0); // load of top level
    add(1'b0,1'b0,1'b1,4'd1,1'b1, 4'd1,4'd4,1'b1,1'b0); // back-to-back change
    add(1'b0,1'b0,1'b0,4'd0,1'b1, 4'd1,4'd4,1'b0,1'b0);

    for (int i = 0; i < vq.size(); i++) begin
      inc_i = vq[i].inc;
      dec_i = vq[i].dec;
      load_i = vq[i].load;
      value_i = vq[i].value;
      bus.code_ready_i = vq[i].ready;
      cyc();
      check_state($sformatf("row%0d", i), vq[i].lvl, vq[i].code, vq[i].vld, vq[i].err);
      if (bus.code_valid_o) begin
        check($sformatf("row%0d decode", i), decode(bus.code_o), level_o);
      end
    end
    inc_i = 1'b0;
    dec_i = 1'b0;
    load_i = 1'b0;

    // Backpressure: intermediate levels are dropped, only the newest is resent.
    bus.code_ready_i = 1'b0;
    cyc();
    load_i = 1'b1;
    value_i = 4'd1;
    cyc();
    load_i = 1'b0;
    check_state("bp load", 4'd1, 4'd4, 1'b1, 1'b0);
    for (int p = 0; p < 3; p++) begin
      inc_i = 1'b1;
      cyc();
      inc_i = 1'b0;
      cyc();
      check_state($sformatf("bp inc%0d", p), 4'(p + 2), 4'd4, 1'b1, 1'b0);
    end
    bus.code_ready_i = 1'b1;
    cyc();
    check_state("bp resend", 4'd4, 4'd1, 1'b1, 1'b0);
    check("bp resend decode", decode(bus.code_o), level_o);
    cyc();
    check_state("bp idle", 4'd4, 4'd1, 1'b0, 1'b0);

    // Reset during SEND drops the transfer.
    bus.code_ready_i = 1'b0;
    inc_i = 1'b1;
    cyc();
    inc_i = 1'b0;
    check_state("rs send", 4'd5, 4'd0, 1'b1, 1'b0);
    reset = 1'b1;
    cyc();
    check_state("rs reset", 4'd0, 4'hF, 1'b0, 1'b0);
    check("rs code", bus.code_o, 4'hF);
    reset = 1'b0;
    bus.code_ready_i = 1'b1;
    cyc();
    cyc();
    check_state("rs after", 4'd0, 4'hF, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
